// File: rtl/multicycle_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl_pkg
// Shared definitions for the multicycle RV32I main controller: FSM state
// encoding, the opcodes it decodes and the mux/ALU select encodings it drives.
// ---------------------------------------------------------------------------
package multicycle_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_JAL,
        S_BEQ,
        S_ILLEGAL,
        S_MEMERR
    } state_e;

    // Instr[6:0] opcodes
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    // ALUOp
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ALUSrcA
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    // ALUSrcB
    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // ResultSrc
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

    // States that hold a memory access open and wait on MemReady.
    function automatic logic is_mem_wait(input state_e s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_mem_watchdog.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl_mem_watchdog
// Counts consecutive stalled cycles of one memory access and flags expiry.
//   clk_i     clock, rising edge
//   rst_i     asynchronous active-high reset, clears the count
//   clr_i     clear the count (controller is changing state)
//   en_i      access is stalled this cycle (count it)
//   expire_o  this stalled cycle is the last one allowed; abort the access
// MEM_TIMEOUT = 0 disables expiry. The count saturates instead of wrapping.
// ---------------------------------------------------------------------------
module multicycle_ctrl_mem_watchdog #(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned TW          = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam logic [TW-1:0] LastCnt = TW'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);
    localparam logic [TW-1:0] CntMax  = '1;

    logic [TW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != CntMax)) begin
            cnt_d = cnt_q + TW'(1);
        end
    end

    assign expire_o = (MEM_TIMEOUT != 0) && en_i && (cnt_q == LastCnt);

endmodule

// File: rtl/multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl
// Main control FSM of the multicycle RV32I core: fetch, decode, execute,
// memory and writeback over a shared memory and ALU, with MemReady stalls and
// a watchdog that aborts memory accesses that never complete.
//   CLK, RST            clock / asynchronous active-high reset (-> S_IDLE)
//   op                  Instr[6:0]
//   Zero                ALU zero flag (qualifies branches)
//   MemReady            memory finishes the current access this cycle
//   MemReq, MemWrite    memory access in progress / store
//   IRWrite, PCWrite    instruction+OldPC load / PC load
//   RegWrite            register-file write
//   AdrSrc, ALUSrcA/B, ALUOp, ResultSrc   datapath selects
//   Illegal, MemErr     one-cycle pulses: bad opcode / memory watchdog abort
// ---------------------------------------------------------------------------
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned TW          = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [6:0] op,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       MemReq,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       AdrSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] ResultSrc,
    output logic       Illegal,
    output logic       MemErr
);

    state_e state_q, state_d;
    logic   wd_expire;
    logic   pc_update;
    logic   branch;

    // Counter restarts whenever the FSM moves, so each access gets a full budget.
    multicycle_ctrl_mem_watchdog #(
        .MEM_TIMEOUT(MEM_TIMEOUT),
        .TW         (TW)
    ) u_watchdog (
        .clk_i   (CLK),
        .rst_i   (RST),
        .clr_i   (state_d != state_q),
        .en_i    (is_mem_wait(state_q) && !MemReady),
        .expire_o(wd_expire)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // MemReady is checked before the watchdog so a late completion still wins.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH: begin
                if (MemReady)       state_d = S_DECODE;
                else if (wd_expire) state_d = S_MEMERR;
            end
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECR;
                    OP_I:         state_d = S_EXECI;
                    OP_JAL:       state_d = S_JAL;
                    OP_BEQ:       state_d = S_BEQ;
                    default:      state_d = S_ILLEGAL;
                endcase
            end
            S_MEMADR: state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD: begin
                if (MemReady)       state_d = S_MEMWB;
                else if (wd_expire) state_d = S_MEMERR;
            end
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR: begin
                if (MemReady)       state_d = S_FETCH;
                else if (wd_expire) state_d = S_MEMERR;
            end
            S_EXECR:   state_d = S_ALUWB;
            S_EXECI:   state_d = S_ALUWB;
            S_ALUWB:   state_d = S_FETCH;
            S_JAL:     state_d = S_ALUWB;
            S_BEQ:     state_d = S_FETCH;
            S_ILLEGAL: state_d = S_FETCH;
            S_MEMERR:  state_d = S_FETCH;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        MemReq    = 1'b0;
        IRWrite   = 1'b0;
        pc_update = 1'b0;
        branch    = 1'b0;
        RegWrite  = 1'b0;
        MemWrite  = 1'b0;
        AdrSrc    = 1'b0;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_RD2;
        ALUOp     = ALUOP_ADD;
        ResultSrc = RES_ALUOUT;
        Illegal   = 1'b0;
        MemErr    = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                MemReq    = 1'b1;
                ALUSrcA   = SRCA_PC;
                ALUSrcB   = SRCB_FOUR;
                ALUOp     = ALUOP_ADD;
                ResultSrc = RES_ALURES;
                // IR and PC only load on the cycle the instruction word arrives.
                IRWrite   = MemReady;
                pc_update = MemReady;
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                ALUOp   = ALUOP_ADD;
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_RD1;
                ALUSrcB = SRCB_IMM;
                ALUOp   = ALUOP_ADD;
            end
            S_MEMRD: begin
                MemReq    = 1'b1;
                AdrSrc    = 1'b1;
                ResultSrc = RES_ALUOUT;
            end
            S_MEMWB: begin
                ResultSrc = RES_DATA;
                RegWrite  = 1'b1;
            end
            S_MEMWR: begin
                MemReq    = 1'b1;
                AdrSrc    = 1'b1;
                ResultSrc = RES_ALUOUT;
                MemWrite  = 1'b1;
            end
            S_EXECR: begin
                ALUSrcA = SRCA_RD1;
                ALUSrcB = SRCB_RD2;
                ALUOp   = ALUOP_FUNCT;
            end
            S_EXECI: begin
                ALUSrcA = SRCA_RD1;
                ALUSrcB = SRCB_IMM;
                ALUOp   = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                ResultSrc = RES_ALUOUT;
                RegWrite  = 1'b1;
            end
            S_JAL: begin
                ALUSrcA   = SRCA_OLDPC;
                ALUSrcB   = SRCB_FOUR;
                ALUOp     = ALUOP_ADD;
                ResultSrc = RES_ALUOUT;
                pc_update = 1'b1;
            end
            S_BEQ: begin
                ALUSrcA   = SRCA_RD1;
                ALUSrcB   = SRCB_RD2;
                ALUOp     = ALUOP_SUB;
                ResultSrc = RES_ALUOUT;
                branch    = 1'b1;
            end
            S_ILLEGAL: Illegal = 1'b1;
            S_MEMERR:  MemErr  = 1'b1;
            default: ;
        endcase
    end

    assign PCWrite = pc_update | (branch & Zero);

endmodule
